// File: rtl/theme_player.sv
// Title-theme sample player: fetches 16-bit words over a req/ack port, decodes
// them to signed PCM at one sample per DIV clocks. Define THEME_LOOP_EN to loop.
module theme_player #(
  parameter int          DIV        = 4800,
  parameter logic [17:0] START_ADDR = 18'h00000,
  parameter logic [17:0] END_ADDR   = 18'h3FFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        playing,
  output logic        theme_rom_req,
  input  logic        theme_rom_ack,
  output logic [17:0] theme_rom_addr,
  input  logic [15:0] theme_rom_dout,
  output logic [15:0] sample_out,
  output logic        sample_strobe,
  output logic [7:0]  underruns,
  output logic [1:0]  dbg_state
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

`ifdef THEME_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY, S_LAST} state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  div_cnt, div_nx;
  logic [12:0]    buf_word, buf_nx;
  logic [17:0]    addr, addr_nx;
  logic [17:0]    rom_addr_nx;
  logic           req_nx, discard, discard_nx;
  logic [15:0]    sample_nx;
  logic           strobe_nx;
  logic [7:0]     underruns_nx;
  logic           tick, ack_live, ack_drop, pending;
  logic           unused_low_bits;

  // Low three bits of each ROM word carry no audio information.
  assign unused_low_bits = ^theme_rom_dout[2:0];

  // ROM port: req rises with addr and both hold until the single-cycle ack, where
  // dout is valid. A started request is always completed; a discarded one is
  // consumed by the discard flag instead of the playback path.
  assign tick     = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign ack_live = theme_rom_ack && theme_rom_req && !discard;
  assign ack_drop = theme_rom_ack && theme_rom_req && discard;
  assign pending  = theme_rom_req && !theme_rom_ack;

  assign playing   = (state != S_IDLE);
  assign dbg_state = state;

  function automatic logic [15:0] decode(input logic [12:0] em);
    logic signed [16:0] s;
    s = {{7{~em[9]}}, ~em[9], em[8:0]};
    s = s <<< em[12:10];
    s = s >>> 1;
    return s[15:0];
  endfunction

  always_comb begin
    state_nx     = state;
    div_nx       = (state == S_IDLE) ? '0 : (tick ? '0 : div_cnt + DIV_ONE);
    buf_nx       = buf_word;
    addr_nx      = addr;
    rom_addr_nx  = theme_rom_addr;
    req_nx       = theme_rom_req;
    discard_nx   = discard;
    sample_nx    = sample_out;
    strobe_nx    = 1'b0;
    underruns_nx = underruns;

    if (ack_drop) begin
      discard_nx = 1'b0;
      req_nx     = 1'b0;
    end

    case (state)
      S_FETCH: begin
        if (ack_live) begin
          buf_nx = theme_rom_dout[15:3];
          req_nx = 1'b0;
          if (addr == END_ADDR) begin
            state_nx = S_LAST;
          end else begin
            addr_nx  = addr + 18'd1;
            state_nx = S_READY;
          end
        end else if (!theme_rom_req && !discard) begin
          // Re-issue after a discarded fetch has drained.
          req_nx      = 1'b1;
          rom_addr_nx = addr;
        end
        if (tick && (underruns != 8'hFF)) underruns_nx = underruns + 8'd1;
      end
      S_READY, S_LAST: begin
        if (tick) begin
          sample_nx = decode(buf_word);
          strobe_nx = 1'b1;
          if (state == S_READY) begin
            state_nx    = S_FETCH;
            req_nx      = 1'b1;
            rom_addr_nx = addr;
          end else if (LOOP_EN) begin
            state_nx    = S_FETCH;
            addr_nx     = START_ADDR;
            req_nx      = 1'b1;
            rom_addr_nx = START_ADDR;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: ;
    endcase

    if (stop && !start) begin
      state_nx   = S_IDLE;
      sample_nx  = 16'h0000;
      strobe_nx  = 1'b0;
      req_nx     = pending;
      discard_nx = pending;
    end

    if (start) begin
      state_nx     = S_FETCH;
      addr_nx      = START_ADDR;
      underruns_nx = 8'h00;
      div_nx       = '0;
      sample_nx    = sample_out;
      strobe_nx    = 1'b0;
      req_nx       = 1'b1;
      discard_nx   = pending;
      if (!pending) rom_addr_nx = START_ADDR;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      div_cnt        <= '0;
      buf_word       <= '0;
      addr           <= START_ADDR;
      theme_rom_addr <= START_ADDR;
      theme_rom_req  <= 1'b0;
      discard        <= 1'b0;
      sample_out     <= 16'h0000;
      sample_strobe  <= 1'b0;
      underruns      <= 8'h00;
    end else begin
      state          <= state_nx;
      div_cnt        <= div_nx;
      buf_word       <= buf_nx;
      addr           <= addr_nx;
      theme_rom_addr <= rom_addr_nx;
      theme_rom_req  <= req_nx;
      discard        <= discard_nx;
      sample_out     <= sample_nx;
      sample_strobe  <= strobe_nx;
      underruns      <= underruns_nx;
    end
  end

endmodule

// File: tb/tb_theme_player.sv
// Directed bench for theme_player: one instance over the full ROM, one over the
// last three words; both fed by latency-configurable ROM responders.
module tb_theme_player;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;

  logic        start = 1'b0, stop = 1'b0;
  logic        playing, req, ack, strobe;
  logic [17:0] addr;
  logic [15:0] dout, sample;
  logic [7:0]  underruns;
  logic [1:0]  dbg_state;

  logic        e_start = 1'b0, e_stop = 1'b0;
  logic        e_playing, e_req, e_ack, e_strobe;
  logic [17:0] e_addr;
  logic [15:0] e_dout, e_sample;
  logic [7:0]  e_underruns;
  logic [1:0]  e_dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat = 2;
  bit          no_ack = 1'b0;
  logic [15:0] exp_q[$];
  logic [17:0] e_addr_q[$];

  theme_player #(.DIV(8), .START_ADDR(18'h00000), .END_ADDR(18'h3FFFF)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .stop(stop), .playing(playing),
    .theme_rom_req(req), .theme_rom_ack(ack), .theme_rom_addr(addr), .theme_rom_dout(dout),
    .sample_out(sample), .sample_strobe(strobe), .underruns(underruns), .dbg_state(dbg_state)
  );

  theme_player #(.DIV(8), .START_ADDR(18'h3FFFD), .END_ADDR(18'h3FFFF)) u_end (
    .clk_sys(clk_sys), .reset(reset), .start(e_start), .stop(e_stop), .playing(e_playing),
    .theme_rom_req(e_req), .theme_rom_ack(e_ack), .theme_rom_addr(e_addr), .theme_rom_dout(e_dout),
    .sample_out(e_sample), .sample_strobe(e_strobe), .underruns(e_underruns), .dbg_state(e_dbg_state)
  );

  // Clock / reset
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rom_word(input logic [17:0] a);
    logic [31:0] t;
    case (a)
      18'd0:   t = 32'h1000;
      18'd1:   t = 32'hE000;
      18'd2:   t = 32'hFFF8;
      18'd3:   t = 32'h0FF8;
      default: t = 32'(a) * 32'h1357 + 32'h2468;
    endcase
    return t[15:0];
  endfunction

  function automatic logic [15:0] ref_decode(input logic [15:0] w);
    int e, m, v;
    logic [31:0] vb;
    e  = int'(w[15:13]);
    m  = int'(w[12:3]);
    v  = (m - 512) * (1 << e);
    v  = v >>> 1;
    vb = v;
    return vb[15:0];
  endfunction

  // ROM responders: ack after lat cycles of req, one cycle wide.
  initial begin
    int cnt;
    cnt = 0; ack = 1'b0; dout = '0;
    forever begin
      @(negedge clk_sys);
      ack = 1'b0;
      if (req) begin
        cnt++;
        if (!no_ack && cnt >= lat) begin
          ack = 1'b1; dout = rom_word(addr); cnt = 0;
        end
      end else cnt = 0;
    end
  end

  initial begin
    int cnt;
    cnt = 0; e_ack = 1'b0; e_dout = '0;
    forever begin
      @(negedge clk_sys);
      e_ack = 1'b0;
      if (e_req) begin
        cnt++;
        if (cnt >= 2) begin
          e_ack = 1'b1; e_dout = rom_word(e_addr); cnt = 0;
        end
      end else cnt = 0;
    end
  end

  // Each new request on the end-of-ROM instance must match the next expected address.
  initial begin
    logic req_d;
    req_d = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (e_req && !req_d) begin
        if (e_addr_q.size() == 0) check_eq("end_extra_req", 32'(e_addr), 32'h7FFFFFFF);
        else check_eq("end_req_addr", 32'(e_addr), 32'(e_addr_q.pop_front()));
      end
      req_d = e_req;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at the following negedge.
  task automatic pulse_start(input bit on_end);
    if (on_end) e_start = 1'b1; else start = 1'b1;
    @(negedge clk_sys);
    e_start = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_stop(input bit on_end);
    if (on_end) e_stop = 1'b1; else stop = 1'b1;
    @(negedge clk_sys);
    e_stop = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_strobe(input bit on_end, input string tag, output int at_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_sys);
      if (on_end ? e_strobe : strobe) seen = 1'b1;
    end
    at_cyc = cyc;
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    else if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 32'd0, 32'd1);
    else check_eq(tag, 32'(on_end ? e_sample : sample), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_idle(input bit on_end);
    for (int k = 0; k < 100 && (on_end ? e_req : req); k++) @(negedge clk_sys);
    check_eq("idle_req", 32'(on_end ? e_req : req), 32'd0);
  endtask

  initial begin
    int t, tp, c0, hi, nstb;
    bit run;

    // Reset state
    repeat (3) @(negedge clk_sys);
    check_eq("rst_playing", 32'(playing), 32'd0);
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'h00000);
    check_eq("rst_e_addr", 32'(e_addr), 32'h3FFFD);
    check_eq("rst_sample", 32'(sample), 32'd0);
    check_eq("rst_strobe", 32'(strobe), 32'd0);
    check_eq("rst_underruns", 32'(underruns), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_eq("idle_after_rst", 32'({playing, req, strobe}), 32'd0);

    // Decode of four hand-picked words, one strobe every 8 cycles
    lat = 2;
    exp_q.delete();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h8000);
    exp_q.push_back(16'h7FC0); exp_q.push_back(16'hFFFF);
    pulse_start(0);
    check_eq("start_req", 32'({playing, req}), 32'd3);
    check_eq("start_addr", 32'(addr), 32'h00000);
    tp = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(0, "dec_sample", t);
      check_eq("dec_gap", 32'(t - tp), 32'd8);
      tp = t;
    end
    check_eq("dec_underruns", 32'(underruns), 32'd0);
    pulse_stop(0);
    check_eq("stop_playing", 32'(playing), 32'd0);
    check_eq("stop_sample", 32'(sample), 32'd0);
    check_eq("stop_strobe", 32'(strobe), 32'd0);
    wait_idle(0);

    // Underrun: latency 20 leaves two missed ticks per word
    lat = 20;
    exp_q.delete();
    exp_q.push_back(ref_decode(rom_word(18'd0)));
    exp_q.push_back(ref_decode(rom_word(18'd1)));
    pulse_start(0);
    c0 = cyc;
    wait_strobe(0, "und_sample", t);
    check_eq("und_gap1", 32'(t - c0), 32'd24);
    check_eq("und_cnt1", 32'(underruns), 32'd2);
    tp = t;
    wait_strobe(0, "und_sample", t);
    check_eq("und_gap2", 32'(t - tp), 32'd24);
    check_eq("und_cnt2", 32'(underruns), 32'd4);
    nstb = 0;
    repeat (12) begin
      @(negedge clk_sys);
      if (strobe) nstb++;
    end
    check_eq("und_no_strobe", 32'(nstb), 32'd0);
    check_eq("und_hold", 32'(sample), 32'h8000);
    check_eq("und_cnt3", 32'(underruns), 32'd5);
    pulse_stop(0);
    wait_idle(0);

    // Stop mid-fetch: ack lands 5 cycles after the stop takes effect
    lat = 7;
    pulse_start(0);
    @(negedge clk_sys);
    pulse_stop(0);
    check_eq("smf_playing", 32'(playing), 32'd0);
    check_eq("smf_sample", 32'(sample), 32'd0);
    hi = 0; run = 1'b1; nstb = 0;
    if (req) hi++;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_sys);
      if (strobe) nstb++;
      if (run && req) hi++;
      else run = 1'b0;
    end
    check_eq("smf_req_hold", 32'(hi), 32'd5);
    check_eq("smf_req_end", 32'(req), 32'd0);
    check_eq("smf_no_strobe", 32'(nstb), 32'd0);

    // Restart while the fetch of word 0x10 is outstanding
    lat = 2;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(ref_decode(rom_word(18'(i))));
    pulse_start(0);
    tp = cyc;
    for (int i = 0; i < 16; i++) begin
      wait_strobe(0, "play_sample", t);
      check_eq("play_gap", 32'(t - tp), 32'd8);
      tp = t;
    end
    exp_q.push_back(ref_decode(rom_word(18'd0)));
    exp_q.push_back(ref_decode(rom_word(18'd1)));
    pulse_start(0);
    c0 = cyc;
    check_eq("rs_hold_req", 32'({playing, req}), 32'd3);
    check_eq("rs_hold_addr", 32'(addr), 32'h00010);
    @(negedge clk_sys);
    check_eq("rs_drop_req", 32'(req), 32'd0);
    @(negedge clk_sys);
    check_eq("rs_new_req", 32'(req), 32'd1);
    check_eq("rs_new_addr", 32'(addr), 32'h00000);
    wait_strobe(0, "rs_sample", t);
    check_eq("rs_gap", 32'(t - c0), 32'd8);
    tp = t;
    wait_strobe(0, "rs_sample", t);
    check_eq("rs_gap2", 32'(t - tp), 32'd8);
    check_eq("rs_underruns", 32'(underruns), 32'd0);
    pulse_stop(0);
    wait_idle(0);

    // Underrun counter saturation with the ROM never answering
    no_ack = 1'b1;
    pulse_start(0);
    nstb = 0;
    repeat (2100) begin
      @(negedge clk_sys);
      if (strobe) nstb++;
    end
    check_eq("sat_underruns", 32'(underruns), 32'd255);
    check_eq("sat_no_strobe", 32'(nstb), 32'd0);
    check_eq("sat_playing", 32'(playing), 32'd1);
    pulse_stop(0);
    no_ack = 1'b0;
    wait_idle(0);

    // End of ROM on the three-word instance
    exp_q.delete();
    e_addr_q.push_back(18'h3FFFD); e_addr_q.push_back(18'h3FFFE); e_addr_q.push_back(18'h3FFFF);
    exp_q.push_back(ref_decode(rom_word(18'h3FFFD)));
    exp_q.push_back(ref_decode(rom_word(18'h3FFFE)));
    exp_q.push_back(ref_decode(rom_word(18'h3FFFF)));
    pulse_start(1);
    tp = cyc;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(1, "end_sample", t);
      check_eq("end_gap", 32'(t - tp), 32'd8);
      tp = t;
    end
`ifdef THEME_LOOP_EN
    check_eq("loop_playing", 32'(e_playing), 32'd1);
    e_addr_q.push_back(18'h3FFFD); e_addr_q.push_back(18'h3FFFE); e_addr_q.push_back(18'h3FFFF);
    exp_q.push_back(ref_decode(rom_word(18'h3FFFD)));
    exp_q.push_back(ref_decode(rom_word(18'h3FFFE)));
    for (int i = 0; i < 2; i++) begin
      wait_strobe(1, "loop_sample", t);
      check_eq("loop_gap", 32'(t - tp), 32'd8);
      tp = t;
    end
    pulse_stop(1);
    wait_idle(1);
    check_eq("loop_stopped", 32'(e_playing), 32'd0);
`else
    check_eq("end_playing", 32'(e_playing), 32'd0);
    nstb = 0;
    repeat (30) begin
      @(negedge clk_sys);
      if (e_strobe) nstb++;
    end
    check_eq("end_no_strobe", 32'(nstb), 32'd0);
    check_eq("end_req", 32'(e_req), 32'd0);
    check_eq("end_hold", 32'(e_sample), 32'(ref_decode(rom_word(18'h3FFFF))));
`endif
    check_eq("end_addr_left", 32'(e_addr_q.size()), 32'd0);

    // Asynchronous reset in the middle of playback
    lat = 2;
    exp_q.delete();
    exp_q.push_back(ref_decode(rom_word(18'd0)));
    exp_q.push_back(ref_decode(rom_word(18'd1)));
    pulse_start(0);
    wait_strobe(0, "ar_sample", t);
    wait_strobe(0, "ar_sample", t);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_sample", 32'(sample), 32'd0);
    check_eq("ar_req_play", 32'({playing, req, strobe}), 32'd0);
    check_eq("ar_addr", 32'(addr), 32'h00000);
    check_eq("ar_state", 32'(dbg_state), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/theme_player.md
Name: theme_player

Overview:
- Playback engine for the title-theme sample ROM: 512 kB, presented as 256k x 16-bit words.
- Sound CPU side issues start/stop pulses. Block fetches words from SDRAM via req/ack, decodes each word to signed 16-bit PCM at a fixed rate (default 20 kHz from 96 MHz) and feeds the audio mixer.
- Sits between the sound command decode (upstream) and the mixer (downstream).

Parameters:
- DIV, 4800, clk_sys cycles per output sample (96 MHz / 4800 = 20 kHz).
- START_ADDR, 18'h00000, first word address.
- END_ADDR, 18'h3FFFF, last word address (inclusive).

Ports:
- clk_sys  in  1  system clock, 96 MHz
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse: (re)start playback at START_ADDR
- stop  in  1  1-cycle pulse: stop playback
- playing  out  1  high while playback is active
- theme_rom_req  out  1  fetch request, held until ack
- theme_rom_ack  in  1  1-cycle pulse, theme_rom_dout valid in the same cycle
- theme_rom_addr  out  18  word address; stable while req high
- theme_rom_dout  in  16  ROM word
- sample_out  out  16  signed PCM, registered
- sample_strobe  out  1  1-cycle pulse when sample_out updates
- underruns  out  8  saturating count of ticks with no word ready

Behaviour:
- Reset: playing=0, theme_rom_req=0, theme_rom_addr=START_ADDR, sample_out=0, sample_strobe=0, underruns=0, divider=0, buffer empty, state IDLE, discard flag=0.
- States: IDLE, FETCH (req high, waiting ack), READY (buffer full, waiting tick), LAST (final word fetched, waiting its tick).
- Divider: counts 0..DIV-1 while playing. Tick = cycle where count==DIV-1. Cleared on start, held at 0 in IDLE.
- Start, in any state:
  - Next cycle: playing=1, addr=START_ADDR, underruns=0, divider=0, buffer emptied, state FETCH, req=1.
  - If a request was outstanding, see the discard rule.
- FETCH:
  - On ack: buffer <= dout.
  - If addr==END_ADDR, go to LAST; else addr <= addr+1 and go to READY.
  - req drops the cycle after ack.
- Tick with buffer full (READY or LAST):
  - Next cycle: sample_out <= decode(buffer), sample_strobe=1, buffer empty.
  - From READY: go to FETCH with req=1.
  - From LAST: go to IDLE, playing=0; sample_out keeps the final value.
- Tick with buffer empty (still FETCH):
  - No strobe, sample_out held, underruns += 1, saturating at 255.
  - The late word is used at the next tick; no word is skipped.
- Decode:
  - e = w[15:13]; m = w[12:3]; w[2:0] ignored.
  - s = (m - 512) as 10-bit signed, sign-extended to 17 bits.
  - sample = (s <<< e) >>> 1, truncated to 16 bits. Result is always in range.
- Stop:
  - Next cycle: state IDLE, playing=0, sample_out=0, sample_strobe=0, buffer empty.
- Discard rule:
  - If stop or start occurs while req=1 and ack is not yet received, req stays high (SDRAM handshake is never aborted) and the discard flag is set.
  - The matching ack is dropped, the flag clears, req drops.
  - On a restart, a new req is raised the cycle after the discarded ack.
- Start and stop in the same cycle: start wins.
- ack while req=0 and discard flag=0: ignored.
- Address wraps only via START_ADDR reload, never by overflow.

Optional Feature:
- Macro THEME_LOOP_EN.
- Defined: at a tick in LAST, the sample is output, addr <= START_ADDR, state FETCH, playing stays 1. Playback loops until stop.
- Undefined: LAST ends in IDLE as above.

Test Plan:
- Decode: DIV=8, ROM words 0x1000, 0xE000, 0xFFF8, 0x0FF8, ack latency 2 -> sample_out sequence 0x0000, 0x8000, 0x7FC0, 0xFFFF, one strobe per 8 cycles, underruns=0.
- End of ROM: START_ADDR=0x3FFFD, END_ADDR=0x3FFFF -> exactly 3 strobes, addresses 0x3FFFD..0x3FFFF requested once each, playing falls the cycle after the 3rd strobe, req stays 0.
- Underrun: DIV=8, ack latency 20 -> strobes only on ticks after data is present, sample_out held in between, underruns increments per missed tick and saturates at 255 on a long run.
- Stop mid-fetch: stop while req=1, ack arrives 5 cycles later -> sample_out=0 and playing=0 next cycle, req held until ack, then 0; no strobe.
- Restart mid-fetch: start at addr 0x00010 with fetch pending -> pending ack discarded, new req at START_ADDR the cycle after it, first strobe DIV cycles after start at earliest.
- Loop (THEME_LOOP_EN): 2-word range -> strobe stream alternates word0/word1 decode indefinitely, playing stays 1; async reset mid-stream clears all outputs immediately.
